// File: rtl/register_alias_table.sv
// Register alias table plus free list for a two-lane rename stage.
// Translates sources, allocates new physical destinations, recycles tags released by the ROB.
module register_alias_table (
  input  logic       clk,
  input  logic       res_n,
  input  logic       valid_int_id2rat,
  input  logic       valid_ls_id2rat,
  input  logic       store,
  input  logic [4:0] rs1_int_id2rat,
  input  logic [4:0] rs2_int_id2rat,
  input  logic [4:0] rd_int_id2rat,
  input  logic [4:0] rs1_ls_id2rat,
  input  logic [4:0] rs2_ls_id2rat,
  input  logic [4:0] rd_ls_id2rat,
  input  logic [5:0] freeMeUp_0_rob2rat,
  input  logic [5:0] freeMeUp_1_rob2rat,
  output logic [5:0] rs1_int_rat2rf,
  output logic [5:0] rs2_int_rat2rf,
  output logic [5:0] rs1_ls_rat2rf,
  output logic [5:0] rs2_ls_rat2rf,
  output logic [5:0] rd_rat2rsint,
  output logic [5:0] rd_rat2rsls,
  output logic [5:0] freeMeUp_int_rat2rob,
  output logic [5:0] freeMeUp_ls_rat2rob
);

  logic [5:0] map_q [32];
  logic [5:0] map_d [32];
  logic [5:0] fl_q  [32];
  logic [5:0] fl_d  [32];
  logic [4:0] head_q, head_d, tail_q, tail_d;
  logic [5:0] count_q, count_d;

  logic [5:0] rs1_int_q, rs1_int_d, rs2_int_q, rs2_int_d;
  logic [5:0] rs1_ls_q, rs1_ls_d, rs2_ls_q, rs2_ls_d;
  logic [5:0] rd_int_q, rd_int_d, rd_ls_q, rd_ls_d;
  logic [5:0] fm_int_q, fm_int_d, fm_ls_q, fm_ls_d;

  logic       int_req, ls_req, int_alloc, ls_alloc;
  logic [4:0] head_p1;
  logic [5:0] int_tag, ls_tag;
  logic [5:0] occ;
  logic [4:0] tail_w;

  // NOTE: every comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    rs1_int_d = '0;
    rs2_int_d = '0;
    rs1_ls_d  = '0;
    rs2_ls_d  = '0;
    rd_int_d  = '0;
    rd_ls_d   = '0;
    fm_int_d  = '0;
    fm_ls_d   = '0;
    map_d     = map_q;
    fl_d      = fl_q;

    int_req   = valid_int_id2rat && (rd_int_id2rat != 5'd0);
    ls_req    = valid_ls_id2rat && !store && (rd_ls_id2rat != 5'd0);
    int_alloc = int_req && (count_q != 6'd0);
    ls_alloc  = ls_req && (count_q > (int_alloc ? 6'd1 : 6'd0));
    head_p1   = head_q + 5'd1;
    int_tag   = fl_q[head_q];
    ls_tag    = int_alloc ? fl_q[head_p1] : fl_q[head_q];

    if (valid_int_id2rat) begin
      rs1_int_d = map_q[rs1_int_id2rat];
      rs2_int_d = map_q[rs2_int_id2rat];
      if (int_alloc) begin
        rd_int_d = int_tag;
        fm_int_d = map_q[rd_int_id2rat];
      end
    end

    // The integer lane is older: ls sources and previous mapping see its new tag.
    if (valid_ls_id2rat) begin
      rs1_ls_d = (int_alloc && rs1_ls_id2rat == rd_int_id2rat) ? int_tag : map_q[rs1_ls_id2rat];
      rs2_ls_d = (int_alloc && rs2_ls_id2rat == rd_int_id2rat) ? int_tag : map_q[rs2_ls_id2rat];
      if (ls_alloc) begin
        rd_ls_d = ls_tag;
        fm_ls_d = (int_alloc && rd_ls_id2rat == rd_int_id2rat) ? int_tag : map_q[rd_ls_id2rat];
      end
    end

    if (int_alloc) map_d[rd_int_id2rat] = int_tag;
    if (ls_alloc)  map_d[rd_ls_id2rat]  = ls_tag;

    // Pops free their slots before returns land; a return into a full ring is dropped.
    occ    = count_q - {5'd0, int_alloc} - {5'd0, ls_alloc};
    tail_w = tail_q;
    if (freeMeUp_0_rob2rat != 6'd0 && occ < 6'd32) begin
      fl_d[tail_w] = freeMeUp_0_rob2rat;
      tail_w       = tail_w + 5'd1;
      occ          = occ + 6'd1;
    end
    if (freeMeUp_1_rob2rat != 6'd0 && occ < 6'd32) begin
      fl_d[tail_w] = freeMeUp_1_rob2rat;
      tail_w       = tail_w + 5'd1;
      occ          = occ + 6'd1;
    end

    head_d  = head_q + {4'd0, int_alloc} + {4'd0, ls_alloc};
    tail_d  = tail_w;
    count_d = occ;
  end

  // NOTE: the table and free list are reset explicitly; their reset contents are architectural state.
  always_ff @(posedge clk) begin
    if (res_n) begin
      for (int i = 0; i < 32; i++) begin
        map_q[i] <= 6'(i);
        fl_q[i]  <= 6'(i + 32);
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 6'd32;
      rs1_int_q <= '0;
      rs2_int_q <= '0;
      rs1_ls_q  <= '0;
      rs2_ls_q  <= '0;
      rd_int_q  <= '0;
      rd_ls_q   <= '0;
      fm_int_q  <= '0;
      fm_ls_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      map_q     <= map_d;
      fl_q      <= fl_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rs1_int_q <= rs1_int_d;
      rs2_int_q <= rs2_int_d;
      rs1_ls_q  <= rs1_ls_d;
      rs2_ls_q  <= rs2_ls_d;
      rd_int_q  <= rd_int_d;
      rd_ls_q   <= rd_ls_d;
      fm_int_q  <= fm_int_d;
      fm_ls_q   <= fm_ls_d;
    end
  end

  assign rs1_int_rat2rf       = rs1_int_q;
  assign rs2_int_rat2rf       = rs2_int_q;
  assign rs1_ls_rat2rf        = rs1_ls_q;
  assign rs2_ls_rat2rf        = rs2_ls_q;
  assign rd_rat2rsint         = rd_int_q;
  assign rd_rat2rsls          = rd_ls_q;
  assign freeMeUp_int_rat2rob = fm_int_q;
  assign freeMeUp_ls_rat2rob  = fm_ls_q;

endmodule

// File: tb/tb_register_alias_table.sv
// Scoreboard bench for register_alias_table: directed rename scenarios, then random groups
// checked against a queue-based model of the mapping table and free list.
module tb_register_alias_table;

  logic       clk;
  logic       res_n;
  logic       valid_int_id2rat, valid_ls_id2rat, store;
  logic [4:0] rs1_int_id2rat, rs2_int_id2rat, rd_int_id2rat;
  logic [4:0] rs1_ls_id2rat, rs2_ls_id2rat, rd_ls_id2rat;
  logic [5:0] freeMeUp_0_rob2rat, freeMeUp_1_rob2rat;
  logic [5:0] rs1_int_rat2rf, rs2_int_rat2rf, rs1_ls_rat2rf, rs2_ls_rat2rf;
  logic [5:0] rd_rat2rsint, rd_rat2rsls, freeMeUp_int_rat2rob, freeMeUp_ls_rat2rob;

  register_alias_table dut (
    .clk                  (clk),
    .res_n                (res_n),
    .valid_int_id2rat     (valid_int_id2rat),
    .valid_ls_id2rat      (valid_ls_id2rat),
    .store                (store),
    .rs1_int_id2rat       (rs1_int_id2rat),
    .rs2_int_id2rat       (rs2_int_id2rat),
    .rd_int_id2rat        (rd_int_id2rat),
    .rs1_ls_id2rat        (rs1_ls_id2rat),
    .rs2_ls_id2rat        (rs2_ls_id2rat),
    .rd_ls_id2rat         (rd_ls_id2rat),
    .freeMeUp_0_rob2rat   (freeMeUp_0_rob2rat),
    .freeMeUp_1_rob2rat   (freeMeUp_1_rob2rat),
    .rs1_int_rat2rf       (rs1_int_rat2rf),
    .rs2_int_rat2rf       (rs2_int_rat2rf),
    .rs1_ls_rat2rf        (rs1_ls_rat2rf),
    .rs2_ls_rat2rf        (rs2_ls_rat2rf),
    .rd_rat2rsint         (rd_rat2rsint),
    .rd_rat2rsls          (rd_rat2rsls),
    .freeMeUp_int_rat2rob (freeMeUp_int_rat2rob),
    .freeMeUp_ls_rat2rob  (freeMeUp_ls_rat2rob)
  );

  typedef struct packed {
    logic       rst;
    logic       vi;
    logic [4:0] rs1i, rs2i, rdi;
    logic       vl, st;
    logic [4:0] rs1l, rs2l, rdl;
    logic [5:0] f0, f1;
  } grp_t;

  typedef struct packed {
    logic [5:0] rs1_int, rs2_int, rs1_ls, rs2_ls, rd_int, rd_ls, fm_int, fm_ls;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference state: architectural->physical map, and the free tags in pop order.
  int ref_map[32];
  int ref_fl[$];
  int rob_pool[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void ref_reset();
    for (int i = 0; i < 32; i++) ref_map[i] = i;
    ref_fl.delete();
    for (int i = 0; i < 32; i++) ref_fl.push_back(32 + i);
  endfunction

  function automatic exp_t ref_step(input grp_t g);
    exp_t e;
    int   int_tag, ls_tag;
    e = '0;
    if (g.rst) begin
      ref_reset();
      return e;
    end
    int_tag = -1;
    ls_tag  = -1;
    if (g.vi) begin
      e.rs1_int = 6'(ref_map[g.rs1i]);
      e.rs2_int = 6'(ref_map[g.rs2i]);
      if (g.rdi != 0 && ref_fl.size() > 0) begin
        int_tag  = ref_fl.pop_front();
        e.rd_int = 6'(int_tag);
        e.fm_int = 6'(ref_map[g.rdi]);
      end
    end
    if (g.vl) begin
      e.rs1_ls = (int_tag >= 0 && g.rs1l == g.rdi) ? 6'(int_tag) : 6'(ref_map[g.rs1l]);
      e.rs2_ls = (int_tag >= 0 && g.rs2l == g.rdi) ? 6'(int_tag) : 6'(ref_map[g.rs2l]);
      if (!g.st && g.rdl != 0 && ref_fl.size() > 0) begin
        ls_tag  = ref_fl.pop_front();
        e.rd_ls = 6'(ls_tag);
        e.fm_ls = (int_tag >= 0 && g.rdl == g.rdi) ? 6'(int_tag) : 6'(ref_map[g.rdl]);
      end
    end
    if (int_tag >= 0) ref_map[g.rdi] = int_tag;
    if (ls_tag >= 0)  ref_map[g.rdl] = ls_tag;
    if (g.f0 != 0 && ref_fl.size() < 32) ref_fl.push_back(int'(g.f0));
    if (g.f1 != 0 && ref_fl.size() < 32) ref_fl.push_back(int'(g.f1));
    return e;
  endfunction

  task automatic issue(input grp_t g);
    exp_t e;
    @(negedge clk);
    res_n              = g.rst;
    valid_int_id2rat   = g.vi;
    rs1_int_id2rat     = g.rs1i;
    rs2_int_id2rat     = g.rs2i;
    rd_int_id2rat      = g.rdi;
    valid_ls_id2rat    = g.vl;
    store              = g.st;
    rs1_ls_id2rat      = g.rs1l;
    rs2_ls_id2rat      = g.rs2l;
    rd_ls_id2rat       = g.rdl;
    freeMeUp_0_rob2rat = g.f0;
    freeMeUp_1_rob2rat = g.f1;
    e = ref_step(g);
    exp_q.push_back(e);
    if (g.rst) rob_pool.delete();
    else begin
      if (e.fm_int != 0) rob_pool.push_back(int'(e.fm_int));
      if (e.fm_ls != 0)  rob_pool.push_back(int'(e.fm_ls));
    end
  endtask

  function automatic grp_t g_nop();
    g_nop = '0;
  endfunction

  function automatic grp_t g_rst();
    g_rst = '0;
    g_rst.rst = 1'b1;
  endfunction

  function automatic grp_t g_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    g_add = '0;
    g_add.vi = 1'b1; g_add.rdi = rd; g_add.rs1i = a; g_add.rs2i = b;
  endfunction

  function automatic grp_t g_ld(input logic [4:0] rd, input logic [4:0] a);
    g_ld = '0;
    g_ld.vl = 1'b1; g_ld.rdl = rd; g_ld.rs1l = a;
  endfunction

  function automatic grp_t g_both(input grp_t a, input grp_t b);
    g_both = grp_t'(a | b);
  endfunction

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
  endfunction

  task automatic gen_rand(output grp_t g);
    g = '0;
    if ($urandom_range(0, 149) == 0) begin
      g.rst = 1'b1;
      return;
    end
    g.vi   = 1'($urandom_range(0, 1));
    g.rs1i = rand_reg(); g.rs2i = rand_reg(); g.rdi = rand_reg();
    g.vl   = 1'($urandom_range(0, 1));
    g.st   = ($urandom_range(0, 3) == 0);
    g.rs1l = rand_reg(); g.rs2l = rand_reg(); g.rdl = rand_reg();
    if (rob_pool.size() > 0 && $urandom_range(0, 2) != 0) g.f0 = 6'(rob_pool.pop_front());
    if (rob_pool.size() > 0 && $urandom_range(0, 2) != 0) g.f1 = 6'(rob_pool.pop_front());
  endtask

  // Monitor: one result per issued group, visible just after the sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rs1_int", rs1_int_rat2rf, e.rs1_int);
        check("rs2_int", rs2_int_rat2rf, e.rs2_int);
        check("rs1_ls", rs1_ls_rat2rf, e.rs1_ls);
        check("rs2_ls", rs2_ls_rat2rf, e.rs2_ls);
        check("rd_int", rd_rat2rsint, e.rd_int);
        check("rd_ls", rd_rat2rsls, e.rd_ls);
        check("freeMeUp_int", freeMeUp_int_rat2rob, e.fm_int);
        check("freeMeUp_ls", freeMeUp_ls_rat2rob, e.fm_ls);
      end
    end
  end

  initial begin
    grp_t g;
    res_n = 1'b1;
    {valid_int_id2rat, valid_ls_id2rat, store} = '0;
    {rs1_int_id2rat, rs2_int_id2rat, rd_int_id2rat} = '0;
    {rs1_ls_id2rat, rs2_ls_id2rat, rd_ls_id2rat} = '0;
    {freeMeUp_0_rob2rat, freeMeUp_1_rob2rat} = '0;
    ref_reset();

    // Reset, NOP, then LD R1,(R0).
    issue(g_rst());
    issue(g_nop());
    issue(g_ld(5'd1, 5'd0));

    // Rename chain.
    issue(g_rst());
    issue(g_ld(5'd1, 5'd0));
    issue(g_ld(5'd2, 5'd0));
    issue(g_ld(5'd3, 5'd0));
    issue(g_add(5'd4, 5'd1, 5'd2));
    issue(g_add(5'd4, 5'd4, 5'd3));

    // Dual issue with intra-group hazard, then a dependent read.
    issue(g_rst());
    issue(g_both(g_add(5'd5, 5'd1, 5'd2), g_ld(5'd5, 5'd5)));
    issue(g_add(5'd6, 5'd5, 5'd0));

    // Store and R0 destination allocate nothing.
    issue(g_rst());
    g = g_both(g_add(5'd0, 5'd3, 5'd4), g_ld(5'd7, 5'd2));
    g.st = 1'b1;
    issue(g);
    issue(g_ld(5'd1, 5'd0));

    // Exhaustion and return.
    issue(g_rst());
    for (int i = 0; i < 16; i++) issue(g_both(g_add(5'd2, 5'd0, 5'd0), g_ld(5'd3, 5'd0)));
    issue(g_ld(5'd1, 5'd0));
    issue(g_both(g_add(5'd4, 5'd0, 5'd0), g_ld(5'd5, 5'd0)));
    g = g_nop();
    g.f0 = 6'd4;
    g.f1 = 6'd9;
    issue(g);
    issue(g_ld(5'd1, 5'd0));
    issue(g_ld(5'd1, 5'd0));
    issue(g_add(5'd1, 5'd0, 5'd0));

    // Mid-run reset.
    issue(g_rst());
    issue(g_both(g_add(5'd1, 5'd2, 5'd3), g_ld(5'd2, 5'd1)));
    issue(g_add(5'd3, 5'd1, 5'd2));
    issue(g_rst());
    issue(g_ld(5'd1, 5'd0));

    // Random traffic with ROB-style returns of previously reported mappings.
    for (int i = 0; i < 3000; i++) begin
      gen_rand(g);
      issue(g);
    end
    issue(g_nop());

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
